mmio_window: RTL and testbench
==============================

# mmio_window

Parametrised memory-mapped register window for the SR-1 CPU data path. It generalises the fixed reserved-page I/O bytes into configurable counts of read/write and read-only byte registers, with a base address and 16-bit dual-lane byte access. It also adds an auto-incrementing address pointer with a burst counter, per-register write strobes, synchronised read-only inputs and sticky change flags. It sits beside the block RAM on the CPU data bus; its `db_out` is OR'd with the other bus sources.

## Interface
- `BASE`, 15'h7F00, address of the first window byte.
- `NUM_RW`, 16, number of read/write byte registers (offsets 0..NUM_RW-1).
- `NUM_RO`, 16, number of read-only byte registers (offsets NUM_RW..NUM_RW+NUM_RO-1).
- `RW_RESET`, '0, NUM_RW*8-bit packed reset values; byte i is `[8i+7:8i]`.
- Elaboration check: BASE+NUM_RW+NUM_RO-1 ≤ 15'h7FFF, and NUM_RW+NUM_RO ≥ 1.

- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `data_bus`  in  16  CPU data bus; lane A = [7:0], lane B = [15:8].
- `set_address`  in  1  load the pointer from data_bus[14:0].
- `step`  in  1  advance the pointer and decrement the burst count.
- `set_count`  in  1  load the burst count from data_bus[15:0].
- `half_mode`  in  1  1 = byte access (lane A only); 0 = 16-bit access (lanes A and B).
- `read`  in  1  read enable.
- `write`  in  1  write enable.
- `ro_value`  in  NUM_RO*8  asynchronous read-only sources; byte j at `[8j+7:8j]`.
- `db_out`  out  16  read data; 0 on any lane not driven by this block.
- `rw_value`  out  NUM_RW*8  current read/write register contents.
- `rw_strobe`  out  NUM_RW  one-cycle pulse when that register was written.
- `ro_changed`  out  NUM_RO  sticky flag: synchronised value changed since the last read.
- `address`  out  15  current pointer.
- `count`  out  16  remaining burst count.
- `done`  out  1  one-cycle pulse when count goes 1→0.
- `overrun`  out  1  sticky flag: step issued while count == 0.

## Operation
- Lane addresses:
  - addr_a = address.
  - addr_b = address+1, modulo 2^15 (7FFF wraps to 0000).
  - A lane hits when BASE ≤ addr < BASE+NUM_RW+NUM_RO; offset = addr−BASE.
- Lane enables:
  - Lane A is enabled for read/write when `read`/`write` is high.
  - Lane B is enabled only when `~half_mode`.
- Reads: combinational.
  - db_out[7:0] = register at addr_a when lane A is enabled and hits, else 0.
  - db_out[15:8] = register at addr_b under the same rule for lane B.
  - RO offsets return the synchronised value.
- Writes:
  - Lane A writes data_bus[7:0]; lane B writes data_bus[15:8].
  - Writes to RO offsets and to non-hitting addresses are ignored.
  - The two lanes never address the same byte.
- Pointer update priority:
  - `set_address` beats `step`.
  - `step` adds 1 when half_mode=1, else 2 (modulo 2^15).
  - A read or write in the same cycle as a pointer update uses the old address.
- Burst counter:
  - `set_count` loads count, clears overrun and beats a simultaneous step's decrement.
  - `step` with count > 0 decrements count.
  - `step` with count == 0 leaves count at 0, still moves the pointer, and sets overrun.
- RO path: 2-flop synchroniser per byte. ro_changed[j] sets when the second stage differs from its previous value.
- ro_changed clear: the flag clears on any lane read of that byte. If a set and a clear happen in the same cycle, set wins.

## Timing
- Reset values:
  - address 0, count 0, done 0, overrun 0.
  - rw_value = RW_RESET.
  - rw_strobe 0, ro_changed 0, synchroniser stages 0.
- Reset is asynchronous and may assert mid-burst; all state returns to the reset values immediately.
- Write latency:
  - rw_value updates on the edge that samples `write`.
  - rw_strobe pulses for the following cycle only.
  - A repeated write re-pulses the strobe even if the data is unchanged.
- RO latency: an ro_value change is visible on db_out 2 cycles later. ro_changed asserts 3 cycles after the change.
- done is registered: high for the cycle after the step edge that made count 0.
- Read data is valid in the same cycle as the address and `read`. No wait states.

## Test plan
- Reset with RW_RESET byte 0 = 8'h01: rw_value[7:0]=01, db_out=0, address=0, count=0, all flags 0.
- set_address=BASE, write=1, half_mode=0, data_bus=16'hBEEF: reg0=EF, reg1=BE, rw_strobe=2'b11 for one cycle. A subsequent read gives db_out=BEEF.
- Pointer at BASE+NUM_RW−1, full-width write: only the RW byte (lane A) changes. The lane-B RO byte is unchanged. A read returns the synchronised RO value on [15:8].
- set_count=3, then 4 steps with half_mode=0: address advances by 2 per step. done pulses after the 3rd step. overrun sets on the 4th. A new set_count=5 clears overrun.
- ro_value byte 0 changes 00→5A: ro_changed[0]=1 three cycles later. A read clears it. A change coinciding with the read keeps it set.
- Address 7FFF with half_mode=0: lane B targets 0000. It is outside the window, so db_out[15:8]=0 and no write occurs.

Source files
------------

// File: rtl/mmio_window.sv
// rtl/mmio_window.sv - memory-mapped byte register window with auto-increment pointer
//
// Purpose: a parametrised window of NUM_RW read/write and NUM_RO read-only byte
// registers at BASE. Access is byte-wide (lane A) or 16-bit (lanes A and B).
// An auto-incrementing pointer with a burst counter selects the address.
//
// Ports:
//   clk, reset    rising-edge clock; asynchronous active-high reset
//   data_bus      write data / pointer / count source; lane A [7:0], lane B [15:8]
//   set_address   load pointer from data_bus[14:0]
//   step          advance pointer (+1 byte mode, +2 word mode) and decrement count
//   set_count     load burst count from data_bus, clear overrun
//   half_mode     1 = lane A only, 0 = lanes A and B
//   read, write   access enables
//   ro_value      asynchronous read-only sources, byte j at [8j+7:8j]
//   db_out        combinational read data, 0 on undriven lanes (OR'd onto the bus)
//   rw_value      read/write register contents
//   rw_strobe     one-cycle pulse per written register
//   ro_changed    sticky per-byte change flags, cleared by reading the byte
//   address       current pointer
//   count         remaining burst count
//   done          one-cycle pulse after count reaches 0
//   overrun       sticky: step issued with count == 0
module mmio_window #(
  parameter logic [14:0]          BASE     = 15'h7F00,
  parameter int                   NUM_RW   = 16,
  parameter int                   NUM_RO   = 16,
  parameter logic [NUM_RW*8-1:0]  RW_RESET = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [15:0]           data_bus,
  input  logic                  set_address,
  input  logic                  step,
  input  logic                  set_count,
  input  logic                  half_mode,
  input  logic                  read,
  input  logic                  write,
  input  logic [NUM_RO*8-1:0]   ro_value,
  output logic [15:0]           db_out,
  output logic [NUM_RW*8-1:0]   rw_value,
  output logic [NUM_RW-1:0]     rw_strobe,
  output logic [NUM_RO-1:0]     ro_changed,
  output logic [14:0]           address,
  output logic [15:0]           count,
  output logic                  done,
  output logic                  overrun
);

  localparam int TOTAL = NUM_RW + NUM_RO;
  localparam int LAST  = int'(BASE) + TOTAL - 1;

  generate
    if (LAST > 32'h7FFF || TOTAL < 1) begin : g_bad_params
      $error("mmio_window: window exceeds address space or is empty");
    end
  endgenerate

  logic [14:0]         addr_b;
  logic                hit_a, hit_b;
  logic [14:0]         off_a, off_b;
  logic [7:0]          rd_a, rd_b;
  logic                rd_en_a, rd_en_b, wr_en_a, wr_en_b;
  logic [NUM_RW-1:0]   wr_sel_a, wr_sel_b;
  logic [NUM_RO-1:0]   ro_clr;
  logic [NUM_RO*8-1:0] ro_s1, ro_s2, ro_prev;

  // Lane B naturally wraps 7FFF -> 0000 in 15-bit arithmetic.
  assign addr_b = address + 15'd1;

  // Compare in 16 bits so BASE+TOTAL cannot overflow at the top of memory.
  assign hit_a = (address >= BASE) && ({1'b0, address} < ({1'b0, BASE} + 16'(TOTAL)));
  assign hit_b = (addr_b  >= BASE) && ({1'b0, addr_b}  < ({1'b0, BASE} + 16'(TOTAL)));
  assign off_a = address - BASE;
  assign off_b = addr_b - BASE;

  assign rd_en_a = read  && hit_a;
  assign rd_en_b = read  && ~half_mode && hit_b;
  assign wr_en_a = write && hit_a;
  assign wr_en_b = write && ~half_mode && hit_b;

  always_comb begin
    rd_a     = 8'h00;
    rd_b     = 8'h00;
    wr_sel_a = '0;
    wr_sel_b = '0;
    ro_clr   = '0;
    for (int i = 0; i < NUM_RW; i++) begin
      if (off_a == 15'(i)) begin
        rd_a        = rw_value[8*i +: 8];
        wr_sel_a[i] = wr_en_a;
      end
      if (off_b == 15'(i)) begin
        rd_b        = rw_value[8*i +: 8];
        wr_sel_b[i] = wr_en_b;
      end
    end
    // RO bytes return the second synchroniser stage; any lane read clears the flag.
    for (int j = 0; j < NUM_RO; j++) begin
      if (off_a == 15'(NUM_RW + j)) begin
        rd_a      = ro_s2[8*j +: 8];
        ro_clr[j] = ro_clr[j] | rd_en_a;
      end
      if (off_b == 15'(NUM_RW + j)) begin
        rd_b      = ro_s2[8*j +: 8];
        ro_clr[j] = ro_clr[j] | rd_en_b;
      end
    end
    db_out = {(rd_en_b ? rd_b : 8'h00), (rd_en_a ? rd_a : 8'h00)};
  end

  // Register file. Lanes never address the same byte, so the order is arbitrary.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rw_value  <= RW_RESET;
      rw_strobe <= '0;
    end else begin
      rw_strobe <= wr_sel_a | wr_sel_b;
      for (int i = 0; i < NUM_RW; i++) begin
        if (wr_sel_a[i]) begin
          rw_value[8*i +: 8] <= data_bus[7:0];
        end else if (wr_sel_b[i]) begin
          rw_value[8*i +: 8] <= data_bus[15:8];
        end
      end
    end
  end

  // Read-only path: two-flop synchroniser plus a history stage for change detect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ro_s1      <= '0;
      ro_s2      <= '0;
      ro_prev    <= '0;
      ro_changed <= '0;
    end else begin
      ro_s1   <= ro_value;
      ro_s2   <= ro_s1;
      ro_prev <= ro_s2;
      for (int j = 0; j < NUM_RO; j++) begin
        if (ro_s2[8*j +: 8] != ro_prev[8*j +: 8]) begin
          ro_changed[j] <= 1'b1;
        end else if (ro_clr[j]) begin
          ro_changed[j] <= 1'b0;
        end
      end
    end
  end

  // Pointer and burst counter; accesses this cycle use the old address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      address <= '0;
      count   <= '0;
      done    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (set_address) begin
        address <= data_bus[14:0];
      end else if (step) begin
        address <= address + (half_mode ? 15'd1 : 15'd2);
      end

      done <= 1'b0;
      if (set_count) begin
        count   <= data_bus;
        overrun <= 1'b0;
      end else if (step) begin
        if (count != 16'd0) begin
          count <= count - 16'd1;
          done  <= (count == 16'd1);
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mmio_window.sv
// tb/tb_mmio_window.sv - scoreboard testbench for mmio_window
module tb_mmio_window;

  localparam int NUM_RW = 16;
  localparam int NUM_RO = 16;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [15:0]           data_bus = '0;
  logic                  set_address = 1'b0;
  logic                  step = 1'b0;
  logic                  set_count = 1'b0;
  logic                  half_mode = 1'b0;
  logic                  read = 1'b0;
  logic                  write = 1'b0;
  logic [NUM_RO*8-1:0]   ro_value = '0;
  logic [15:0]           db_out;
  logic [NUM_RW*8-1:0]   rw_value;
  logic [NUM_RW-1:0]     rw_strobe;
  logic [NUM_RO-1:0]     ro_changed;
  logic [14:0]           address;
  logic [15:0]           count;
  logic                  done;
  logic                  overrun;

  mmio_window #(
    .BASE     (15'h7F00),
    .NUM_RW   (NUM_RW),
    .NUM_RO   (NUM_RO),
    .RW_RESET (128'h01)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .data_bus    (data_bus),
    .set_address (set_address),
    .step        (step),
    .set_count   (set_count),
    .half_mode   (half_mode),
    .read        (read),
    .write       (write),
    .ro_value    (ro_value),
    .db_out      (db_out),
    .rw_value    (rw_value),
    .rw_strobe   (rw_strobe),
    .ro_changed  (ro_changed),
    .address     (address),
    .count       (count),
    .done        (done),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  localparam int S_DB = 0, S_RWLO = 1, S_STB = 2, S_CHG = 3, S_ADDR = 4,
                 S_CNT = 5, S_DONE = 6, S_OVR = 7, S_RWHI = 8;

  typedef struct {
    string       name;
    int          sig;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;

  task automatic expect_val(input string name, input int sig, input logic [31:0] exp);
    exp_t e;
    e.name = name;
    e.sig  = sig;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  function automatic logic [31:0] sample(input int sig);
    case (sig)
      S_DB:    return {16'h0, db_out};
      S_RWLO:  return {16'h0, rw_value[15:0]};
      S_STB:   return {16'h0, rw_strobe};
      S_CHG:   return {16'h0, ro_changed};
      S_ADDR:  return {17'h0, address};
      S_CNT:   return {16'h0, count};
      S_DONE:  return {31'h0, done};
      S_OVR:   return {31'h0, overrun};
      S_RWHI:  return {16'h0, rw_value[127:112]};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Monitor: outputs are sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin : monitor
    exp_t        e;
    logic [31:0] act;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      act = sample(e.sig);
      checks++;
      if (act !== e.exp) begin
        fails++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_addr(input logic [14:0] a);
    set_address = 1'b1;
    data_bus    = {1'b0, a};
    tick();
    set_address = 1'b0;
    data_bus    = '0;
  endtask

  task automatic load_count(input logic [15:0] c);
    set_count = 1'b1;
    data_bus  = c;
    tick();
    set_count = 1'b0;
    data_bus  = '0;
  endtask

  initial begin
    repeat (2) tick();
    reset = 1'b0;
    expect_val("reset_rw_lo", S_RWLO, 32'h0001);
    expect_val("reset_db", S_DB, 32'h0);
    expect_val("reset_addr", S_ADDR, 32'h0);
    expect_val("reset_count", S_CNT, 32'h0);
    expect_val("reset_done", S_DONE, 32'h0);
    expect_val("reset_overrun", S_OVR, 32'h0);
    expect_val("reset_strobe", S_STB, 32'h0);
    expect_val("reset_changed", S_CHG, 32'h0);
    tick();

    // Full-width write at BASE, then read back.
    load_addr(15'h7F00);
    half_mode = 1'b0;
    write     = 1'b1;
    data_bus  = 16'hBEEF;
    tick();
    write    = 1'b0;
    data_bus = '0;
    expect_val("wr_rw_lo", S_RWLO, 32'hBEEF);
    expect_val("wr_strobe", S_STB, 32'h0003);
    read = 1'b1;
    expect_val("wr_readback", S_DB, 32'hBEEF);
    tick();
    read = 1'b0;
    expect_val("strobe_one_cycle", S_STB, 32'h0);
    write    = 1'b1;
    data_bus = 16'hBEEF;
    tick();
    write    = 1'b0;
    data_bus = '0;
    expect_val("strobe_repeat", S_STB, 32'h0003);
    tick();
    expect_val("strobe_repeat_end", S_STB, 32'h0);

    // RO byte 0 at BASE+16: synchroniser latency, change flag, clear on read.
    load_addr(15'h7F10);
    half_mode      = 1'b1;
    ro_value[7:0]  = 8'h5A;
    tick();
    tick();
    expect_val("ro_chg_not_yet", S_CHG, 32'h0);
    tick();
    expect_val("ro_chg_set", S_CHG, 32'h0001);
    read = 1'b1;
    expect_val("ro_read_5a", S_DB, 32'h005A);
    tick();
    read = 1'b0;
    expect_val("ro_chg_cleared", S_CHG, 32'h0);
    ro_value[7:0] = 8'hA5;
    tick();
    tick();
    read = 1'b1;
    expect_val("ro_read_a5", S_DB, 32'h00A5);
    tick();
    expect_val("ro_set_wins", S_CHG, 32'h0001);
    tick();
    read = 1'b0;
    expect_val("ro_chg_cleared2", S_CHG, 32'h0);

    // Last RW byte: lane B lands on RO byte 0 and must not be written.
    load_addr(15'h7F0F);
    half_mode = 1'b0;
    write     = 1'b1;
    data_bus  = 16'h1234;
    tick();
    write    = 1'b0;
    data_bus = '0;
    expect_val("edge_rw_hi", S_RWHI, 32'h3400);
    expect_val("edge_strobe", S_STB, 32'h8000);
    read = 1'b1;
    expect_val("edge_read", S_DB, 32'hA534);
    tick();
    read = 1'b0;

    // Burst counter: done after 3rd step, overrun on 4th.
    load_addr(15'h7F00);
    load_count(16'd3);
    expect_val("burst_count3", S_CNT, 32'd3);
    step = 1'b1;
    tick();
    expect_val("step1_addr", S_ADDR, 32'h7F02);
    expect_val("step1_count", S_CNT, 32'd2);
    expect_val("step1_done", S_DONE, 32'h0);
    tick();
    expect_val("step2_addr", S_ADDR, 32'h7F04);
    expect_val("step2_count", S_CNT, 32'd1);
    expect_val("step2_done", S_DONE, 32'h0);
    tick();
    expect_val("step3_addr", S_ADDR, 32'h7F06);
    expect_val("step3_count", S_CNT, 32'd0);
    expect_val("step3_done", S_DONE, 32'h1);
    expect_val("step3_overrun", S_OVR, 32'h0);
    tick();
    step = 1'b0;
    expect_val("step4_addr", S_ADDR, 32'h7F08);
    expect_val("step4_count", S_CNT, 32'd0);
    expect_val("step4_done", S_DONE, 32'h0);
    expect_val("step4_overrun", S_OVR, 32'h1);
    tick();
    expect_val("overrun_sticky", S_OVR, 32'h1);
    load_count(16'd5);
    expect_val("reload_count", S_CNT, 32'd5);
    expect_val("reload_clr_ovr", S_OVR, 32'h0);

    // set_address beats step; step still decrements count.
    set_address = 1'b1;
    step        = 1'b1;
    data_bus    = 16'h7F20;
    tick();
    set_address = 1'b0;
    data_bus    = '0;
    expect_val("prio_addr", S_ADDR, 32'h7F20);
    expect_val("prio_count", S_CNT, 32'd4);
    half_mode = 1'b1;
    tick();
    step = 1'b0;
    expect_val("half_step_addr", S_ADDR, 32'h7F21);
    expect_val("half_step_count", S_CNT, 32'd3);

    // Top of memory: lane B wraps to 0000, outside the window.
    load_addr(15'h7FFF);
    half_mode = 1'b0;
    write     = 1'b1;
    data_bus  = 16'hAAAA;
    tick();
    write    = 1'b0;
    data_bus = '0;
    expect_val("wrap_no_strobe", S_STB, 32'h0);
    expect_val("wrap_rw_lo", S_RWLO, 32'hBEEF);
    expect_val("wrap_rw_hi", S_RWHI, 32'h3400);
    read = 1'b1;
    expect_val("wrap_read", S_DB, 32'h0);
    tick();
    read = 1'b0;
    step = 1'b1;
    tick();
    step = 1'b0;
    expect_val("wrap_step_addr", S_ADDR, 32'h0001);

    // Asynchronous reset in the middle of a burst.
    load_count(16'd5);
    step = 1'b1;
    tick();
    step = 1'b0;
    expect_val("pre_reset_count", S_CNT, 32'd4);
    tick();
    reset = 1'b1;
    expect_val("async_rst_count", S_CNT, 32'd0);
    expect_val("async_rst_addr", S_ADDR, 32'h0);
    expect_val("async_rst_rw_lo", S_RWLO, 32'h0001);
    expect_val("async_rst_rw_hi", S_RWHI, 32'h0);
    tick();
    reset = 1'b0;
    tick();

    for (int i = 0; i < 5 && sb.size() > 0; i++) tick();
    if (sb.size() > 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
